// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the tiled conv scheduler.
// Holds the FSM state encoding, derived-width helpers and chunk/address arithmetic.
// No logic of its own; imported by conv_scheduler_tiled and conv_weight_loader.
package conv_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ_WIN,
    S_LOAD,
    S_WAIT_LD,
    S_INJECT,
    S_WAIT_LAT,
    S_OUT,
    S_DONE
  } state_t;

  function automatic int win_cnt_w(input int max_win);
    return $clog2(max_win + 1);
  endfunction

  function automatic int otile_w(input int max_otile);
    return $clog2(max_otile + 1);
  endfunction

  // Tile index width; never below one bit so a single-tile build still has a port.
  function automatic int tile_idx_w(input int max_otile);
    return (max_otile > 1) ? $clog2(max_otile) : 1;
  endfunction

  // Number of array-height chunks needed to cover a window (ceiling divide).
  function automatic int n_chunks(input int win_len, input int rows);
    return (win_len + rows - 1) / rows;
  endfunction

  // Weight words consumed per chunk, i.e. the address step between chunk loads.
  function automatic int w_stride(input int rows);
    return rows;
  endfunction

  // Widths for the default 288-byte / 16-tile configuration.
  localparam int WIN_CNT_W = win_cnt_w(288);
  localparam int OTILE_W   = otile_w(16);

endpackage

// File: rtl/conv_weight_loader.sv
// Weight DMA front end: issues one load of NUM_ROWS words at a registered base address.
// Latency: weight_req rises the cycle after i_start; o_done mirrors weight_done while busy.
// Backpressure: weight_req is held until weight_grant; a new i_start is ignored while busy.
// Ports: CLK/RESET; i_start/i_base from the scheduler; weight_req/base/count to the DMA;
//        weight_grant/weight_done from the DMA; o_busy/o_done back to the scheduler.
module conv_weight_loader
  import conv_sched_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int NUM_ROWS = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              weight_grant,
  input  logic              weight_done,
  output logic              weight_req,
  output logic [ADDR_W-1:0] weight_base,
  output logic [10:0]       weight_count,
  output logic              o_busy,
  output logic              o_done
);

  logic              r_req;
  logic              r_busy;
  logic [ADDR_W-1:0] r_base;
  logic [10:0]       r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_base  <= '0;
      r_count <= 11'(NUM_ROWS);
    end else if (i_start && !r_busy) begin
      r_req   <= 1'b1;
      r_busy  <= 1'b1;
      r_base  <= i_base;
      r_count <= 11'(w_stride(NUM_ROWS));
    end else begin
      if (r_req && weight_grant) r_req <= 1'b0;
      // Done is honoured independently of grant so a same-cycle grant+done completes.
      if (r_busy && weight_done) r_busy <= 1'b0;
    end
  end

  assign weight_req   = r_req;
  assign weight_base  = r_base;
  assign weight_count = r_count;
  assign o_busy       = r_busy;
  assign o_done       = r_busy & weight_done;

endmodule

// File: rtl/conv_scheduler_tiled.sv
// Tiled conv scheduler: fetches one window, feeds it chunk by chunk to the PE array per
// output tile, accumulates column sums and emits one NUM_COLS-wide result per tile.
// Latency per chunk: LOAD + weight load + INJECT + PE_LAT+1 cycles; result held until y_ready.
// Ports: start/busy/done/cfg_err control; cfg_* sampled at start; win_* window fetch;
//        weight_* DMA via loader; arr_W_EN/in_weight_above/active_left/out_sum_final to
//        the array; y_valid/y_ready/y_data/y_tile_idx to post-processing.
module conv_scheduler_tiled
  import conv_sched_pkg::*;
#(
  parameter int NUM_ROWS  = 32,
  parameter int NUM_COLS  = 16,
  parameter int A_BITS    = 8,
  parameter int W_BITS    = 8,
  parameter int ACC_BITS  = 32,
  parameter int ADDR_W    = 19,
  parameter int MAX_WIN   = 288,
  parameter int MAX_OTILE = 16,
  parameter int PE_LAT    = NUM_ROWS - 1
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_err,
  input  logic [win_cnt_w(MAX_WIN)-1:0]     cfg_win_len,
  input  logic [otile_w(MAX_OTILE)-1:0]     cfg_n_otile,
  input  logic [ADDR_W-1:0]                 w_base_in,
  output logic                              win_req,
  input  logic                              win_valid,
  input  logic [MAX_WIN*A_BITS-1:0]         win_flat,
  output logic                              weight_req,
  input  logic                              weight_grant,
  output logic [ADDR_W-1:0]                 weight_base,
  output logic [10:0]                       weight_count,
  input  logic                              weight_valid,
  input  logic [NUM_COLS*W_BITS-1:0]        weight_data,
  input  logic                              weight_done,
  output logic                              arr_W_EN,
  output logic [NUM_COLS*W_BITS-1:0]        in_weight_above,
  output logic [NUM_ROWS*A_BITS-1:0]        active_left,
  input  logic [NUM_COLS*ACC_BITS-1:0]      out_sum_final,
  output logic                              y_valid,
  input  logic                              y_ready,
  output logic [NUM_COLS*ACC_BITS-1:0]      y_data,
  output logic [tile_idx_w(MAX_OTILE)-1:0]  y_tile_idx
);

  localparam int WIN_W     = win_cnt_w(MAX_WIN);
  localparam int NOT_W     = otile_w(MAX_OTILE);
  localparam int TIDX_W    = tile_idx_w(MAX_OTILE);
  localparam int MAX_CHUNK = n_chunks(MAX_WIN, NUM_ROWS);
  localparam int CHUNK_W   = $clog2(MAX_CHUNK + 1);
  localparam int PAD_BYTES = MAX_CHUNK * NUM_ROWS;
  localparam int LAT_W     = $clog2(PE_LAT + 2);
  localparam int CH_BITS   = NUM_ROWS * A_BITS;

  state_t                       r_state;
  logic                         r_busy, r_done, r_cfg_err, r_win_req, r_y_valid;
  logic [WIN_W-1:0]             r_win_len;
  logic [NOT_W-1:0]             r_n_otile;
  logic [CHUNK_W-1:0]           r_n_chunk, r_c;
  logic [TIDX_W-1:0]            r_t;
  logic [ADDR_W-1:0]            r_waddr;
  logic [MAX_WIN*A_BITS-1:0]    r_win;
  logic [CH_BITS-1:0]           r_active;
  logic [LAT_W-1:0]             r_lat;
  logic [NUM_COLS*ACC_BITS-1:0] r_psum;
  logic [NUM_COLS*W_BITS-1:0]   r_wabove;

  logic                         w_cfg_bad, w_last_chunk, w_last_tile, w_ld_start, w_ld_done;
  logic                         w_ld_busy;
  logic [PAD_BYTES*A_BITS-1:0]  w_win_pad;
  logic [CH_BITS-1:0]           w_chunk;

  assign w_cfg_bad = (cfg_win_len == '0) || (cfg_win_len > WIN_W'(MAX_WIN)) ||
                     (cfg_n_otile == '0) || (cfg_n_otile > NOT_W'(MAX_OTILE));
  assign w_last_chunk = (r_c == r_n_chunk - CHUNK_W'(1));
  assign w_last_tile  = (NOT_W'(r_t) + NOT_W'(1) == r_n_otile);
  assign w_ld_start   = (r_state == S_LOAD);

  // The latched window already has bytes past win_len zeroed; the pad covers the
  // tail of the last chunk when MAX_WIN is not a multiple of NUM_ROWS.
  always_comb begin
    w_win_pad = '0;
    w_win_pad[MAX_WIN*A_BITS-1:0] = r_win;
  end
  assign w_chunk = w_win_pad[int'(r_c)*CH_BITS +: CH_BITS];

  conv_weight_loader #(.ADDR_W(ADDR_W), .NUM_ROWS(NUM_ROWS)) u_loader (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_start      (w_ld_start),
    .i_base       (r_waddr),
    .weight_grant (weight_grant),
    .weight_done  (weight_done),
    .weight_req   (weight_req),
    .weight_base  (weight_base),
    .weight_count (weight_count),
    .o_busy       (w_ld_busy),
    .o_done       (w_ld_done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_win_req <= 1'b0;
      r_y_valid <= 1'b0;
      r_win_len <= '0;
      r_n_otile <= '0;
      r_n_chunk <= '0;
      r_c       <= '0;
      r_t       <= '0;
      r_waddr   <= '0;
      r_win     <= '0;
      r_active  <= '0;
      r_lat     <= '0;
      r_psum    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_active  <= '0;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_cfg_bad) begin
            r_cfg_err <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_busy    <= 1'b1;
            r_win_req <= 1'b1;
            r_win_len <= cfg_win_len;
            r_n_otile <= cfg_n_otile;
            r_n_chunk <= CHUNK_W'(n_chunks(int'(cfg_win_len), NUM_ROWS));
            r_waddr   <= w_base_in;
            r_state   <= S_REQ_WIN;
          end
        end
        S_REQ_WIN: if (win_valid) begin
          r_win_req <= 1'b0;
          for (int k = 0; k < MAX_WIN; k++)
            r_win[k*A_BITS +: A_BITS] <= (k < int'(r_win_len)) ? win_flat[k*A_BITS +: A_BITS] : '0;
          r_t     <= '0;
          r_c     <= '0;
          r_state <= S_LOAD;
        end
        // Loads run strictly in (tile, chunk) order, so the address just steps by
        // one chunk of words each time instead of multiplying out t*n_chunk+c.
        S_LOAD: begin
          r_waddr <= r_waddr + ADDR_W'(w_stride(NUM_ROWS));
          r_state <= S_WAIT_LD;
        end
        S_WAIT_LD: if (w_ld_done) r_state <= S_INJECT;
        S_INJECT: begin
          r_active <= w_chunk;
          r_lat    <= '0;
          r_state  <= S_WAIT_LAT;
        end
        S_WAIT_LAT: begin
          if (r_lat == LAT_W'(PE_LAT)) begin
            for (int j = 0; j < NUM_COLS; j++)
              r_psum[j*ACC_BITS +: ACC_BITS] <=
                ((r_c == '0) ? ACC_BITS'(0) : r_psum[j*ACC_BITS +: ACC_BITS]) +
                out_sum_final[j*ACC_BITS +: ACC_BITS];
            if (!w_last_chunk) begin
              r_c     <= r_c + CHUNK_W'(1);
              r_state <= S_LOAD;
            end else begin
              r_y_valid <= 1'b1;
              r_state   <= S_OUT;
            end
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        S_OUT: if (r_y_valid && y_ready) begin
          r_y_valid <= 1'b0;
          if (!w_last_tile) begin
            r_t     <= r_t + TIDX_W'(1);
            r_c     <= '0;
            r_state <= S_LOAD;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Weight forwarding is independent of the FSM: the array latches whatever the DMA streams.
  always_ff @(posedge CLK) begin
    if (RESET)             r_wabove <= '0;
    else if (weight_valid) r_wabove <= weight_data;
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign cfg_err         = r_cfg_err;
  assign win_req         = r_win_req;
  assign arr_W_EN        = weight_valid;
  assign in_weight_above = r_wabove;
  assign active_left     = r_active;
  assign y_valid         = r_y_valid;
  assign y_data          = r_psum;
  assign y_tile_idx      = r_t;

endmodule

// File: tb/tb_conv_scheduler_tiled.sv
module tb_conv_scheduler_tiled;
  import conv_sched_pkg::*;

  localparam int NR = 32, NC = 16, AB = 8, WB = 8, ACC = 32, AW = 19, MW = 288, MO = 16;
  localparam int PL = NR - 1;

  logic                 CLK = 1'b0;
  logic                 RESET, start, win_valid, weight_grant, weight_valid, weight_done, y_ready;
  logic                 busy, done, cfg_err, win_req, weight_req, arr_W_EN, y_valid;
  logic [WIN_CNT_W-1:0] cfg_win_len;
  logic [OTILE_W-1:0]   cfg_n_otile;
  logic [AW-1:0]        w_base_in, weight_base;
  logic [MW*AB-1:0]     win_flat;
  logic [10:0]          weight_count;
  logic [NC*WB-1:0]     weight_data, in_weight_above;
  logic [NR*AB-1:0]     active_left;
  logic [NC*ACC-1:0]    out_sum_final, y_data;
  logic [3:0]           y_tile_idx;

  always #5 CLK = ~CLK;

  conv_scheduler_tiled dut (
    .CLK(CLK), .RESET(RESET), .start(start), .busy(busy), .done(done), .cfg_err(cfg_err),
    .cfg_win_len(cfg_win_len), .cfg_n_otile(cfg_n_otile), .w_base_in(w_base_in),
    .win_req(win_req), .win_valid(win_valid), .win_flat(win_flat),
    .weight_req(weight_req), .weight_grant(weight_grant), .weight_base(weight_base),
    .weight_count(weight_count), .weight_valid(weight_valid), .weight_data(weight_data),
    .weight_done(weight_done), .arr_W_EN(arr_W_EN), .in_weight_above(in_weight_above),
    .active_left(active_left), .out_sum_final(out_sum_final),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_tile_idx(y_tile_idx)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            wl;
    int            nt;
    logic [AW-1:0] base;
    int            pat;   // 0: bytes=1, 1: byte k = k mod 7, 2: fixed column sums
    int            wt;
    logic [31:0]   exp;
    bit            err;
    bit            fast;  // DMA grants and completes in the same cycle
  } vec_t;

  vec_t          vecs[9];
  int            wt = 1, mode_fixed = 0, inj_cnt = 0;
  bit            fast_dma = 0;
  logic [31:0]   fix_tbl[2];
  logic [AW-1:0] base_q[$];

  // PE array model: column sum appears on out_sum_final only in the sample cycle.
  initial begin
    int          cnt;
    int          s;
    logic [31:0] val;
    cnt = -1;
    val = '0;
    out_sum_final = {NC{32'hDEADBEEF}};
    forever begin
      @(negedge CLK);
      if (RESET) cnt = -1;
      else begin
        if (cnt >= 0) cnt++;
        if (cnt > PL) cnt = -1;
        if (cnt == 1) chk("active_left_pulse", active_left, '0);
        if (active_left != '0) begin
          s = 0;
          for (int r = 0; r < NR; r++) s += int'(active_left[r*AB +: AB]);
          val = (mode_fixed != 0 && inj_cnt < 2) ? fix_tbl[inj_cnt] : 32'(s * wt);
          inj_cnt++;
          cnt = 0;
        end
      end
      out_sum_final = (cnt == PL) ? {NC{val}} : {NC{32'hDEADBEEF}};
    end
  end

  // Weight DMA model.
  initial begin
    logic [WB-1:0] b;
    weight_grant = 0; weight_valid = 0; weight_done = 0; weight_data = '0;
    forever begin
      @(negedge CLK);
      if (weight_req && !RESET) begin
        base_q.push_back(weight_base);
        chk("weight_count", weight_count, 32);
        if (fast_dma) begin
          weight_grant = 1; weight_done = 1;
          @(negedge CLK);
          weight_grant = 0; weight_done = 0;
        end else begin
          @(negedge CLK);
          weight_grant = 1;
          @(negedge CLK);
          weight_grant = 0;
          for (int i = 0; i < NR; i++) begin
            b = 8'(wt + i);
            weight_valid = 1;
            weight_data  = {NC{b}};
            @(negedge CLK);
            if (i == 0) chk("arr_W_EN_hi", arr_W_EN, 1);
            chk("in_weight_above", in_weight_above, {NC{b}});
          end
          weight_valid = 0; weight_done = 1;
          @(negedge CLK);
          weight_done = 0;
          chk("arr_W_EN_lo", arr_W_EN, 0);
        end
      end
    end
  end

  task automatic check_reset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_cfg_err"}, cfg_err, 0);
    chk({p, "_win_req"}, win_req, 0);
    chk({p, "_weight_req"}, weight_req, 0);
    chk({p, "_weight_base"}, weight_base, 0);
    chk({p, "_weight_count"}, weight_count, 32);
    chk({p, "_in_weight_above"}, in_weight_above, 0);
    chk({p, "_active_left"}, active_left, 0);
    chk({p, "_y_valid"}, y_valid, 0);
    chk({p, "_y_data"}, y_data, 0);
    chk({p, "_y_tile_idx"}, y_tile_idx, 0);
  endtask

  task automatic kick(input int wl, input int nt, input logic [AW-1:0] base, input int pat);
    cfg_win_len = WIN_CNT_W'(wl);
    cfg_n_otile = OTILE_W'(nt);
    w_base_in   = base;
    // Bytes past the window length are garbage that must never reach the array.
    for (int k = 0; k < MW; k++)
      win_flat[k*AB +: AB] = (k >= wl) ? 8'hFF : ((pat == 1) ? 8'(k % 7) : 8'd1);
    base_q.delete();
    inj_cnt = 0;
    start = 1;
    @(negedge CLK);
    start = 0;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    logic [511:0] e;
    bit           seen, stable;
    int           nch;
    wt = v.wt; mode_fixed = (v.pat == 2) ? 1 : 0; fast_dma = v.fast;
    e = {NC{v.exp}};
    kick(v.wl, v.nt, v.base, v.pat);
    if (v.err) begin
      chk("err_cfg_err", cfg_err, 1);
      chk("err_done", done, 1);
      chk("err_busy", busy, 0);
      @(negedge CLK);
      chk("err_cfg_err_pulse", cfg_err, 0);
      chk("err_done_pulse", done, 0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        seen |= win_req | weight_req | busy;
        @(negedge CLK);
      end
      chk("err_no_requests", seen, 0);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_win_req", win_req, 1);
    win_valid = 1;
    @(negedge CLK);
    win_valid = 0;
    chk("win_req_drop", win_req, 0);
    for (int t = 0; t < v.nt; t++) begin
      for (int i = 0; i < 4000 && !y_valid; i++) @(negedge CLK);
      if (!y_valid) begin
        chk("y_valid_timeout", 0, 1);
        return;
      end
      chk("y_data", y_data, e);
      chk("y_tile_idx", y_tile_idx, t);
      if (t == 0 && hold > 0) begin
        seen = 0; stable = 1;
        for (int i = 0; i < hold; i++) begin
          @(negedge CLK);
          seen |= weight_req;
          if (!y_valid || y_data !== e || y_tile_idx !== 4'd0) stable = 0;
        end
        chk("hold_stable", stable, 1);
        chk("hold_no_load", seen, 0);
      end
      y_ready = 1;
      @(negedge CLK);
      y_ready = 0;
      chk("y_valid_after_accept", y_valid, 0);
    end
    chk("done_pulse", done, 1);
    chk("busy_drop", busy, 0);
    @(negedge CLK);
    chk("done_clear", done, 0);
    nch = (v.wl + NR - 1) / NR;
    chk("load_count", base_q.size(), nch * v.nt);
    for (int i = 0; i < base_q.size(); i++)
      chk("weight_base", base_q[i], AW'(v.base + AW'(i * NR)));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    fix_tbl[0] = 32'h7FFFFFF0;
    fix_tbl[1] = 32'h00000020;
    //             wl   nt  base        pat wt exp            err   fast
    vecs[0] = '{  27,  2, 19'h00100,  0,  2, 32'd54,       1'b0, 1'b0};
    vecs[1] = '{  72,  1, 19'h7FFF0,  1,  1, 32'd211,      1'b0, 1'b0};  // sum k mod 7, k<72
    vecs[2] = '{  64,  1, 19'h00000,  2,  0, 32'h80000010, 1'b0, 1'b0};  // wraps past 2^31
    vecs[3] = '{   0,  2, 19'h00000,  0,  1, 32'd0,        1'b1, 1'b0};
    vecs[4] = '{  27, 17, 19'h00000,  0,  1, 32'd0,        1'b1, 1'b0};
    vecs[5] = '{ 289,  1, 19'h00000,  0,  1, 32'd0,        1'b1, 1'b0};
    vecs[6] = '{ 288,  1, 19'h00040,  0,  1, 32'd288,      1'b0, 1'b1};
    vecs[7] = '{  33,  1, 19'h00000,  0,  3, 32'd99,       1'b0, 1'b0};
    vecs[8] = '{   1, 16, 19'h00010,  0,  5, 32'd5,        1'b0, 1'b1};

    RESET = 1; start = 0; win_valid = 0; y_ready = 0;
    cfg_win_len = '0; cfg_n_otile = '0; w_base_in = '0; win_flat = '0;
    repeat (3) @(negedge CLK);
    check_reset("rst0");
    RESET = 0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 0);

    // Backpressure on tile 0 for 10 cycles.
    run_vec(vecs[0], 10);

    // Reset in the middle of chunk 1's latency wait, then a clean run.
    wt = 1; mode_fixed = 0; fast_dma = 0;
    kick(72, 1, 19'h0, 1);
    win_valid = 1;
    @(negedge CLK);
    win_valid = 0;
    for (int i = 0; i < 4000 && inj_cnt < 2; i++) @(negedge CLK);
    chk("rst_mid_reached_chunk1", (inj_cnt >= 2), 1);
    repeat (5) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    check_reset("rst_mid");
    RESET = 0;
    @(negedge CLK);
    run_vec(vecs[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
